// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request channel; allocates TIDs, routes responses by TID, caps in-flight stores.
// Latency: grant to mem_req_valid_o is 1 cycle; response routing is combinational (0 cycles).
// Backpressure: stalled output register blocks all grants; full TID table or store cap withholds req_ready_o.
module wt_mem_req_arbiter #(
    parameter int NrPorts              = 3,
    parameter int TidWidth             = 2,
    parameter int MaxOutstandingStores = 7,
    parameter int AddrWidth            = 64,
    parameter int DataWidth            = 64
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [NrPorts-1:0]                         req_valid_i,
    output logic [NrPorts-1:0]                         req_ready_o,
    input  logic [NrPorts-1:0]                         req_we_i,
    input  logic [NrPorts*AddrWidth-1:0]               req_addr_i,
    input  logic [NrPorts*DataWidth-1:0]               req_wdata_i,
    output logic                                       mem_req_valid_o,
    input  logic                                       mem_req_ready_i,
    output logic                                       mem_req_we_o,
    output logic [AddrWidth-1:0]                       mem_req_addr_o,
    output logic [DataWidth-1:0]                       mem_req_wdata_o,
    output logic [TidWidth-1:0]                        mem_req_tid_o,
    input  logic                                       mem_rsp_valid_i,
    input  logic [TidWidth-1:0]                        mem_rsp_tid_i,
    input  logic [DataWidth-1:0]                       mem_rsp_data_i,
    output logic [NrPorts-1:0]                         rsp_valid_o,
    output logic [DataWidth-1:0]                       rsp_data_o,
    output logic [$clog2(MaxOutstandingStores+1)-1:0]  outstanding_stores_o,
    output logic                                       tid_err_o
);

    localparam int NumTids = 2**TidWidth;
    localparam int PortW   = (NrPorts > 1) ? $clog2(NrPorts) : 1;
    localparam int CntW    = $clog2(MaxOutstandingStores+1);

    typedef struct packed {
        logic             vld;
        logic [PortW-1:0] port;
        logic             we;
    } tid_ent_t;

    tid_ent_t         tid_tbl_q [NumTids];
    logic [PortW-1:0] rr_ptr_q;

    logic                tid_free;
    logic [TidWidth-1:0] free_tid;
    logic                out_free;
    logic                store_ok;
    logic [NrPorts-1:0]  eligible;
    logic                gnt_vld;
    logic [PortW-1:0]    gnt_port;
    logic                gnt_we;
    tid_ent_t            rsp_ent;
    logic                rsp_hit;

    // Lowest-index free entry, looked up from registered state only
    always_comb begin
        tid_free = 1'b0;
        free_tid = '0;
        for (int t = NumTids-1; t >= 0; t--) begin
            if (!tid_tbl_q[t].vld) begin
                tid_free = 1'b1;
                free_tid = TidWidth'(t);
            end
        end
    end

    assign out_free = !mem_req_valid_o || mem_req_ready_i;
    assign store_ok = outstanding_stores_o < CntW'(MaxOutstandingStores);

    always_comb begin
        for (int i = 0; i < NrPorts; i++) begin
            eligible[i] = req_valid_i[i] && tid_free && (!req_we_i[i] || store_ok);
        end
    end

    always_comb begin
        int idx;
        gnt_vld  = 1'b0;
        gnt_port = '0;
        for (int off = 0; off < NrPorts; off++) begin
            idx = (int'(rr_ptr_q) + off) % NrPorts;
            if (!gnt_vld && eligible[idx]) begin
                gnt_vld  = 1'b1;
                gnt_port = PortW'(idx);
            end
        end
        // Holding grants off during reset keeps req_ready_o at zero
        if (!out_free || !rst_ni) begin
            gnt_vld = 1'b0;
        end
    end

    assign gnt_we      = req_we_i[gnt_port];
    assign req_ready_o = gnt_vld ? (NrPorts'(1) << gnt_port) : '0;

    assign rsp_ent     = tid_tbl_q[mem_rsp_tid_i];
    assign rsp_hit     = mem_rsp_valid_i && rsp_ent.vld;
    assign rsp_valid_o = rsp_hit ? (NrPorts'(1) << rsp_ent.port) : '0;
    assign rsp_data_o  = rsp_hit ? mem_rsp_data_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < NumTids; t++) begin
                tid_tbl_q[t] <= '0;
            end
            rr_ptr_q             <= '0;
            outstanding_stores_o <= '0;
            tid_err_o            <= 1'b0;
            mem_req_valid_o      <= 1'b0;
            mem_req_we_o         <= 1'b0;
            mem_req_addr_o       <= '0;
            mem_req_wdata_o      <= '0;
            mem_req_tid_o        <= '0;
        end else begin
            // Freed and allocated entries never coincide: one is valid, the other free
            if (rsp_hit) begin
                tid_tbl_q[mem_rsp_tid_i].vld <= 1'b0;
            end
            if (gnt_vld) begin
                tid_tbl_q[free_tid] <= '{vld: 1'b1, port: gnt_port, we: gnt_we};
                rr_ptr_q <= (gnt_port == PortW'(NrPorts-1)) ? '0 : gnt_port + PortW'(1);
            end

            case ({gnt_vld && gnt_we, rsp_hit && rsp_ent.we})
                2'b10:   outstanding_stores_o <= outstanding_stores_o + CntW'(1);
                2'b01:   outstanding_stores_o <= outstanding_stores_o - CntW'(1);
                default: outstanding_stores_o <= outstanding_stores_o;
            endcase

            if (mem_rsp_valid_i && !rsp_ent.vld) begin
                tid_err_o <= 1'b1;
            end

            if (out_free) begin
                mem_req_valid_o <= gnt_vld;
                if (gnt_vld) begin
                    mem_req_we_o    <= gnt_we;
                    mem_req_addr_o  <= req_addr_i[gnt_port*AddrWidth +: AddrWidth];
                    mem_req_wdata_o <= req_wdata_i[gnt_port*DataWidth +: DataWidth];
                    mem_req_tid_o   <= free_tid;
                end
            end
        end
    end

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Directed and randomized bench for wt_mem_req_arbiter against a transaction-level reference model.
module tb_wt_mem_req_arbiter;

    localparam int NP   = 3;
    localparam int TW   = 3;
    localparam int NT   = 8;
    localparam int MAXS = 7;
    localparam int AW   = 64;
    localparam int DW   = 64;

    logic              clk;
    logic              rst_n;
    logic [NP-1:0]     req_valid, req_ready, req_we;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_wdata;
    logic              mq_valid, mq_ready, mq_we;
    logic [AW-1:0]     mq_addr;
    logic [DW-1:0]     mq_wdata;
    logic [TW-1:0]     mq_tid;
    logic              rsp_v;
    logic [TW-1:0]     rsp_tid;
    logic [DW-1:0]     rsp_data_in;
    logic [NP-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [2:0]        st_cnt;
    logic              tid_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_v [NT];
    int          m_p [NT];
    bit          m_w [NT];
    int          m_cnt, m_rr, m_qt;
    bit          m_qv, m_qwe, m_err;
    logic [63:0] m_qa, m_qd;

    wt_mem_req_arbiter #(
        .NrPorts(NP), .TidWidth(TW), .MaxOutstandingStores(MAXS),
        .AddrWidth(AW), .DataWidth(DW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_req_valid_o(mq_valid), .mem_req_ready_i(mq_ready), .mem_req_we_o(mq_we),
        .mem_req_addr_o(mq_addr), .mem_req_wdata_o(mq_wdata), .mem_req_tid_o(mq_tid),
        .mem_rsp_valid_i(rsp_v), .mem_rsp_tid_i(rsp_tid), .mem_rsp_data_i(rsp_data_in),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .outstanding_stores_o(st_cnt), .tid_err_o(tid_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_v[t] = 0; m_p[t] = 0; m_w[t] = 0;
        end
        m_cnt = 0; m_rr = 0; m_qv = 0; m_qwe = 0; m_qa = '0; m_qd = '0; m_qt = 0; m_err = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ready"},   req_ready, 0);
        chk({tag, "_rspv"},    rsp_valid, 0);
        chk({tag, "_rspd"},    rsp_data, 0);
        chk({tag, "_mqv"},     mq_valid, 0);
        chk({tag, "_mqwe"},    mq_we, 0);
        chk({tag, "_mqaddr"},  mq_addr, 0);
        chk({tag, "_mqwdata"}, mq_wdata, 0);
        chk({tag, "_mqtid"},   mq_tid, 0);
        chk({tag, "_stcnt"},   st_cnt, 0);
        chk({tag, "_tiderr"},  tid_err, 0);
    endtask

    // One clock: randomize payloads, check every output against the model, advance the model
    task automatic cyc();
        int lf, win, rt, p;
        bit hit, hit_we, was_free, bad;
        for (int i = 0; i < NP; i++) begin
            req_addr[i*AW +: AW]  = {$urandom, $urandom};
            req_wdata[i*DW +: DW] = {$urandom, $urandom};
        end
        #1;
        lf = -1;
        for (int t = NT-1; t >= 0; t--) if (!m_v[t]) lf = t;
        was_free = !m_qv || mq_ready;
        win = -1;
        if (rst_n && was_free && lf >= 0) begin
            for (int off = 0; off < NP; off++) begin
                p = (m_rr + off) % NP;
                if (win < 0 && req_valid[p] && (!req_we[p] || m_cnt < MAXS)) win = p;
            end
        end
        rt     = int'(rsp_tid);
        hit    = rsp_v && m_v[rt];
        hit_we = hit && m_w[rt];
        bad    = rsp_v && !m_v[rt];

        chk("req_ready", req_ready, (win < 0) ? 0 : (1 << win));
        chk("rsp_valid", rsp_valid, hit ? (1 << m_p[rt]) : 0);
        if (hit) chk("rsp_data", rsp_data, rsp_data_in);
        chk("mq_valid", mq_valid, m_qv);
        if (m_qv) begin
            chk("mq_we", mq_we, m_qwe);
            chk("mq_addr", mq_addr, m_qa);
            chk("mq_wdata", mq_wdata, m_qd);
            chk("mq_tid", mq_tid, m_qt);
        end
        chk("st_cnt", st_cnt, m_cnt);
        chk("tid_err", tid_err, m_err);

        @(posedge clk);
        if (rst_n) begin
            if (hit) m_v[rt] = 0;
            if (bad) m_err = 1;
            if (win >= 0) begin
                m_v[lf] = 1; m_p[lf] = win; m_w[lf] = req_we[win];
                m_rr = (win + 1) % NP;
            end
            m_cnt = m_cnt + ((win >= 0 && req_we[win]) ? 1 : 0) - (hit_we ? 1 : 0);
            if (was_free) begin
                m_qv = (win >= 0);
                if (win >= 0) begin
                    m_qwe = req_we[win];
                    m_qa  = req_addr[win*AW +: AW];
                    m_qd  = req_wdata[win*DW +: DW];
                    m_qt  = lf;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid = '0;
        mq_ready  = 1'b1;
        for (int t = 0; t < NT; t++) begin
            if (m_v[t]) begin
                rsp_v = 1'b1; rsp_tid = TW'(t); rsp_data_in = {$urandom, $urandom};
                cyc();
            end
        end
        rsp_v = 1'b0;
        cyc();
    endtask

    initial begin
        int nv, pick;
        rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mq_ready = 1'b0; rsp_v = 1'b0; rsp_tid = '0; rsp_data_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Round robin with all ports loading until the table fills
        req_valid = 3'b111; req_we = 3'b000; mq_ready = 1'b1;
        repeat (10) cyc();
        chk("full_no_grant", req_ready, 0);

        // Zero-latency routing, then the freed TID is reused next cycle
        rsp_v = 1'b1; rsp_tid = 3'd1; rsp_data_in = 64'hDEAD_BEEF;
        cyc();
        rsp_v = 1'b0;
        cyc();
        chk("tid1_reused", mq_tid, 1);
        drain();

        // Store cap: only stores on port 2, no responses
        req_valid = 3'b100; req_we = 3'b100;
        repeat (9) cyc();
        chk("store_cap_cnt", st_cnt, 7);
        req_valid = 3'b110;
        cyc();
        req_valid = 3'b100;
        rsp_v = 1'b1; rsp_tid = 3'd0; rsp_data_in = 64'h1;
        cyc();
        rsp_v = 1'b0;
        cyc();
        chk("store_regrant_cnt", st_cnt, 7);
        // Store grant and store response in one cycle
        rsp_v = 1'b1; rsp_tid = 3'd1;
        cyc();
        rsp_tid = 3'd2;
        cyc();
        rsp_v = 1'b0;
        chk("simul_cnt", st_cnt, 6);
        drain();

        // Backpressure: output stalled for five cycles
        req_valid = 3'b111; req_we = 3'b000; mq_ready = 1'b0;
        repeat (6) cyc();
        mq_ready = 1'b1;
        repeat (2) cyc();
        drain();

        // Unallocated TID
        rsp_v = 1'b1; rsp_tid = 3'd3; rsp_data_in = 64'h5;
        cyc();
        rsp_v = 1'b0;
        repeat (2) cyc();
        chk("tid_err_sticky", tid_err, 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            req_valid = NP'($urandom);
            req_we    = NP'($urandom);
            mq_ready  = ($urandom_range(0, 3) != 0);
            nv = 0;
            for (int t = 0; t < NT; t++) if (m_v[t]) nv++;
            rsp_v = 1'b0;
            if (nv > 0 && $urandom_range(0, 1) == 1) begin
                pick = $urandom_range(0, nv - 1);
                for (int t = 0; t < NT; t++) begin
                    if (m_v[t]) begin
                        if (pick == 0) begin
                            rsp_v = 1'b1; rsp_tid = TW'(t);
                        end
                        pick--;
                    end
                end
            end
            rsp_data_in = {$urandom, $urandom};
            cyc();
        end
        drain();

        // Reset with requests in flight
        req_valid = 3'b111; req_we = 3'b001; mq_ready = 1'b1; rsp_v = 1'b0;
        repeat (2) cyc();
        rsp_v = 1'b1; rsp_tid = 3'd0; rsp_data_in = 64'h77;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        model_reset();
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        req_we = 3'b000;
        cyc();
        rsp_v = 1'b0;
        chk("post_reset_port0", mq_tid, 0);
        chk("post_reset_err", tid_err, 1);
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
